// File: rtl/pipe_ctl_track.sv
// Pipelined control tracker: carries the decoded ID control word through EX/MEM/WB,
// inserts bubbles on load-use stall, freezes on memory wait, and counts stalls/retires.
module pipe_ctl_track (
    input  logic        clock,
    input  logic        resetn,
    input  logic        wpcir,
    input  logic        dwreg,
    input  logic        dm2reg,
    input  logic        dwmem,
    input  logic        djal,
    input  logic        dregrt,
    input  logic [4:0]  drd,
    input  logic [4:0]  drt,
    input  logic        mem_ready,
    output logic        ewreg,
    output logic        em2reg,
    output logic        ewmem,
    output logic        ejal,
    output logic [4:0]  ern,
    output logic        mwreg,
    output logic        mm2reg,
    output logic        mwmem,
    output logic [4:0]  mrn,
    output logic        wwreg,
    output logic        wm2reg,
    output logic [4:0]  wrn,
    output logic        freeze,
    output logic [15:0] stall_cnt,
    output logic [31:0] retire_cnt
);

    logic       ev, mv, wv;
    logic [4:0] drn;

    always_comb begin
        drn = drd;
        if (djal)        drn = 5'd31;
        else if (dregrt) drn = drt;
    end

    // Only a valid load/store in MEM can wait on memory; anything else ignores mem_ready.
    assign freeze = mv & (mm2reg | mwmem) & ~mem_ready;

    // NOTE: all state uses non-blocking assignments so every stage samples the
    // pre-edge value of its predecessor; blocking here would collapse the pipe.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ev     <= 1'b0;
            ewreg  <= 1'b0;
            em2reg <= 1'b0;
            ewmem  <= 1'b0;
            ejal   <= 1'b0;
            ern    <= 5'd0;
        end else if (freeze) begin
            // EX holds its instruction; ID inputs are ignored.
        end else if (!wpcir) begin
            ev     <= 1'b0;
            ewreg  <= 1'b0;
            em2reg <= 1'b0;
            ewmem  <= 1'b0;
            ejal   <= 1'b0;
            ern    <= 5'd0;
        end else begin
            ev     <= 1'b1;
            ewreg  <= dwreg;
            em2reg <= dm2reg;
            ewmem  <= dwmem;
            ejal   <= djal;
            ern    <= drn;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mv     <= 1'b0;
            mwreg  <= 1'b0;
            mm2reg <= 1'b0;
            mwmem  <= 1'b0;
            mrn    <= 5'd0;
        end else if (!freeze) begin
            mv     <= ev;
            mwreg  <= ewreg;
            mm2reg <= em2reg;
            mwmem  <= ewmem;
            mrn    <= ern;
        end
    end

    // WB takes a bubble while frozen so the instruction already there retires only once.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wv     <= 1'b0;
            wwreg  <= 1'b0;
            wm2reg <= 1'b0;
            wrn    <= 5'd0;
        end else if (freeze) begin
            wv     <= 1'b0;
            wwreg  <= 1'b0;
            wm2reg <= 1'b0;
            wrn    <= 5'd0;
        end else begin
            wv     <= mv;
            wwreg  <= mwreg;
            wm2reg <= mm2reg;
            wrn    <= mrn;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cnt  <= 16'd0;
            retire_cnt <= 32'd0;
        end else begin
            if (!freeze && !wpcir && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (wv)
                retire_cnt <= retire_cnt + 32'd1;
        end
    end

endmodule

// File: doc/pipe_ctl_track.md
# pipe_ctl_track

Pipelined control tracker for the five-stage CPU. It receives the decoded ID-stage control word from the control unit and carries it through the EX, MEM and WB pipeline registers. It feeds back the EX/MEM destination and write-type signals (ewreg, ern, em2reg, mwreg, mrn, mm2reg) that the control unit uses for forwarding and load-use stall decisions. It also inserts bubbles on stall, freezes the pipe on memory wait, and keeps stall and retire counters.

## Interface
- No parameters.
- clock  in  1  rising-edge system clock
- resetn  in  1  asynchronous, active-low reset
- wpcir  in  1  0 = load-use stall; ID instruction does not advance, bubble enters EX
- dwreg, dm2reg, dwmem, djal, dregrt  in  1 each  ID control word
- drd, drt  in  5 each  ID rd and rt fields
- mem_ready  in  1  data memory done; only sampled when MEM holds a load/store
- ewreg, em2reg, ewmem, ejal  out  1 each  EX-stage control
- ern  out  5  EX destination register
- mwreg, mm2reg, mwmem  out  1 each  MEM-stage control
- mrn  out  5  MEM destination register
- wwreg, wm2reg  out  1 each  WB-stage control
- wrn  out  5  WB destination register
- freeze  out  1  pipeline hold request to fetch/ID (combinational)
- stall_cnt  out  16  saturating count of stall cycles
- retire_cnt  out  32  wrapping count of retired instructions

## Operation
- Destination select in ID:
  - djal=1: rn = 31.
  - else dregrt=1: rn = drt.
  - else rn = drd.
- Each stage has a valid bit: ev, mv, wv. Valid bits are internal.
- freeze = mv & (mm2reg | mwmem) & ~mem_ready.
- Per clock edge, in priority order:
  - resetn=0: all stage registers, valid bits and counters clear to 0. This is asynchronous and applies mid-operation; in-flight instructions are discarded.
  - freeze=1: EX and MEM hold. WB loads a bubble (valid 0, all controls 0, wrn 0). ID inputs are ignored. stall_cnt is not incremented.
  - wpcir=0: EX loads a bubble. MEM←EX and WB←MEM advance. stall_cnt increments, saturating at 16'hFFFF.
  - otherwise: EX←ID with ev=1, MEM←EX, WB←MEM.
- Bubble contents: valid 0, all control bits 0, rn 0.
- retire_cnt increments at every edge where wv=1, wrapping 32'hFFFFFFFF→0. A WB instruction is present for exactly one cycle, so it is counted and committed once, including the first cycle of a freeze.
- Control bits are forwarded unmodified, even when rn=0. Zero-register suppression belongs to the consumers.
- Simultaneous freeze and wpcir=0: freeze wins. EX is not overwritten by a bubble, and stall_cnt is not incremented.

## Timing
- Every output listed above is 0 out of reset.
- Latency from an ID control word sampled at edge N:
  - visible on e* after edge N;
  - on m* after edge N+1;
  - on w* after edge N+2;
  - each additional freeze cycle adds one edge to the M and W latencies.
- freeze is combinational from mv, mm2reg, mwmem and mem_ready, with no register stage. It must settle within the same cycle so fetch/ID can hold.
- ern, em2reg, mrn and mm2reg are registered outputs with no combinational path from the d* inputs. This rules out a loop through the control unit's wpcir.
- mem_ready is ignored whenever MEM holds a bubble or a non-memory instruction.

## Test plan
- Reset: drive activity, assert resetn=0 mid-stream → all outputs 0 immediately, before the next edge. After release, the counters restart from 0.
- Straight-line flow: add with drd=5, dwreg=1, dregrt=0, then lw with drt=7, dregrt=1, dm2reg=1 →
  - ern=5 and then ern=7 on consecutive cycles;
  - mrn=5 one cycle later, with mm2reg=1 arriving alongside mrn=7;
  - retire_cnt=2 after both leave WB.
- jal: djal=1, drd=3, drt=9 → ern=31 and ewreg passes through; wrn=31 two cycles later.
- Load-use stall: wpcir=0 for one cycle after a lw with rn=7 →
  - ewreg=0 and ern=0 in the next cycle;
  - mrn=7 with mm2reg=1;
  - stall_cnt=1; retire_cnt excludes the bubble.
- Memory wait: lw in MEM with mem_ready=0 for 3 cycles →
  - freeze=1 for 3 cycles;
  - ern and mrn are held;
  - WB shows bubbles after the first frozen cycle; the older instruction retires once;
  - wpcir=0 during the freeze leaves stall_cnt unchanged.
- Counter bounds:
  - force 65 540 stall cycles → stall_cnt holds 16'hFFFF;
  - preload retire_cnt to 32'hFFFFFFFF via a run of retirements, then retire one more → 0.
